// File: rtl/lock_sequencer.sv
// Keypad lock sequencer: four-digit PIN entry, timed unlock, lockout after repeated
// failures, and a hold-to-reprogram SETUP mode. One shared saturating timer.
module lock_sequencer #(
  parameter logic [15:0] PIN_DEFAULT   = 16'h1234,
  parameter int unsigned TIME_OPEN     = 3000,
  parameter int unsigned TIME_LOCKOUT  = 10000,
  parameter int unsigned TIME_IDLE_OUT = 5000,
  parameter int unsigned MAX_TRIES     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       hold_reset,
  output logic       unlock,
  output logic       lockout,
  output logic       setup_mode,
  output logic [2:0] digit_cnt,
  output logic       err_pulse,
  output logic       pin_saved
);

  typedef enum logic [2:0] {StIdle, StEntry, StUnlocked, StLockout, StSetup} state_e;

  localparam logic [19:0] OpenLast = 20'(TIME_OPEN - 1);
  localparam logic [19:0] LockLast = 20'(TIME_LOCKOUT - 1);
  localparam logic [19:0] IdleLast = 20'(TIME_IDLE_OUT - 1);

  state_e      state_q, state_d;
  logic        hold_prev_q;
  logic [15:0] entry_q, entry_d, pin_q, pin_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  tries_q, tries_d;
  logic [19:0] timer_q, timer_d, timer_inc;
  logic        unlock_q, unlock_d, lockout_q, lockout_d, setup_q, setup_d;
  logic        err_q, err_d, saved_q, saved_d;
  logic        err_ev, saved_ev;
  logic        hold_rise, is_digit, is_clear;
  logic [15:0] entry_full;

  assign hold_rise  = hold_reset & ~hold_prev_q;
  assign is_digit   = key_valid && (key_code <= 4'd9);
  assign is_clear   = key_valid && (key_code == 4'hA);
  assign entry_full = {entry_q[11:0], key_code};
  assign timer_inc  = (timer_q == '1) ? timer_q : timer_q + 20'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      hold_prev_q <= 1'b0;
      entry_q     <= '0;
      pin_q       <= PIN_DEFAULT;
      cnt_q       <= '0;
      tries_q     <= '0;
      timer_q     <= '0;
      unlock_q    <= 1'b0;
      lockout_q   <= 1'b0;
      setup_q     <= 1'b0;
      err_q       <= 1'b0;
      saved_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_prev_q <= hold_reset;
      entry_q     <= entry_d;
      pin_q       <= pin_d;
      cnt_q       <= cnt_d;
      tries_q     <= tries_d;
      timer_q     <= timer_d;
      unlock_q    <= unlock_d;
      lockout_q   <= lockout_d;
      setup_q     <= setup_d;
      err_q       <= err_d;
      saved_q     <= saved_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    pin_d    = pin_q;
    cnt_d    = cnt_q;
    tries_d  = tries_q;
    timer_d  = timer_inc;
    err_ev   = 1'b0;
    saved_ev = 1'b0;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        // A hold edge beats a simultaneous key; the key is dropped.
        if (hold_rise) begin
          state_d = StSetup;
          cnt_d   = '0;
        end else if (is_digit) begin
          state_d = StEntry;
          entry_d = {12'h000, key_code};
          cnt_d   = 3'd1;
        end
      end
      StEntry: begin
        if (is_clear) begin
          state_d = StIdle;
          cnt_d   = '0;
          timer_d = '0;
        end else if (is_digit) begin
          timer_d = '0;
          if (cnt_q == 3'd3) begin
            cnt_d = '0;
            if (entry_full == pin_q) begin
              state_d = StUnlocked;
              tries_d = '0;
            end else begin
              err_ev  = 1'b1;
              tries_d = tries_q + 8'd1;
              state_d = (32'(tries_q) + 32'd1 >= MAX_TRIES) ? StLockout : StIdle;
            end
          end else begin
            entry_d = entry_full;
            cnt_d   = cnt_q + 3'd1;
          end
        end else if (timer_q == IdleLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          timer_d = '0;
        end
      end
      StUnlocked: begin
        if (hold_rise) begin
          state_d = StSetup;
          cnt_d   = '0;
          timer_d = '0;
        end else if (timer_q == OpenLast) begin
          state_d = StIdle;
          timer_d = '0;
        end
      end
      StLockout: begin
        if (timer_q == LockLast) begin
          state_d = StIdle;
          tries_d = '0;
          timer_d = '0;
        end
      end
      StSetup: begin
        if (is_clear) begin
          cnt_d   = '0;
          timer_d = '0;
        end else if (is_digit) begin
          timer_d = '0;
          if (cnt_q == 3'd3) begin
            pin_d    = entry_full;
            saved_ev = 1'b1;
            tries_d  = '0;
            cnt_d    = '0;
            state_d  = StIdle;
          end else begin
            entry_d = entry_full;
            cnt_d   = cnt_q + 3'd1;
          end
        end else if (timer_q == IdleLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          timer_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    unlock_d  = (state_d == StUnlocked);
    lockout_d = (state_d == StLockout);
    setup_d   = (state_d == StSetup);
    err_d     = err_ev;
    saved_d   = saved_ev;
  end

  assign unlock     = unlock_q;
  assign lockout    = lockout_q;
  assign setup_mode = setup_q;
  assign digit_cnt  = cnt_q;
  assign err_pulse  = err_q;
  assign pin_saved  = saved_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: vector tables pushed through a scoreboard queue, plus bounded
// loops that measure the unlock, lockout and inactivity durations.
module tb_lock_sequencer;

  localparam int TOpen = 3000;
  localparam int TLock = 10000;
  localparam int TIdle = 5000;

  logic       clk = 1'b0;
  logic       reset, key_valid, hold_reset;
  logic [3:0] key_code;
  logic       unlock, lockout, setup_mode, err_pulse, pin_saved;
  logic [2:0] digit_cnt;

  int n_vec = 0;
  int n_bad = 0;

  // exp packs {unlock, lockout, setup_mode, digit_cnt[2:0], err_pulse, pin_saved}
  typedef struct {
    logic       rst_n;
    logic       kv;
    logic [3:0] code;
    logic       hold;
    logic [7:0] exp;
  } vec_t;

  vec_t       ph1[$], ph2[$], ph3a[$], ph3b[$], ph4[$], ph5[$];
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  lock_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .hold_reset (hold_reset),
    .unlock     (unlock),
    .lockout    (lockout),
    .setup_mode (setup_mode),
    .digit_cnt  (digit_cnt),
    .err_pulse  (err_pulse),
    .pin_saved  (pin_saved)
  );

  function automatic vec_t mk(logic r, logic kv, logic [3:0] c, logic h, logic u, logic lo,
                              logic s, logic [2:0] n, logic e, logic ps);
    vec_t v;
    v.rst_n = r;
    v.kv    = kv;
    v.code  = c;
    v.hold  = h;
    v.exp   = {u, lo, s, n, e, ps};
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {unlock, lockout, setup_mode, digit_cnt, err_pulse, pin_saved};
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] got,
                       input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s[%0d]: got u/lo/s/cnt/e/ps=%b, want %b", name, idx, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic apply(input vec_t v, input string name, input int idx);
    @(negedge clk);
    reset      = v.rst_n;
    key_valid  = v.kv;
    key_code   = v.code;
    hold_reset = v.hold;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    check(name, idx, outs(), sb_q.pop_front());
  endtask

  task automatic run(input vec_t t[$], input string name);
    for (int i = 0; i < t.size(); i++) apply(t[i], name, i);
  endtask

  // Idle cycles until every bit of outs() under mask is low; k = cycles taken.
  task automatic steps_until_low(input logic [7:0] mask, input int bound, output int k,
                                 output logic saw_unlock);
    k = 0;
    saw_unlock = 1'b0;
    while (k < bound) begin
      @(negedge clk);
      key_valid = 1'b0;
      @(posedge clk);
      #1;
      k++;
      if (unlock) saw_unlock = 1'b1;
      if ((outs() & mask) == 8'h00) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    logic su;

    // Reset, ignored keys in IDLE, then correct default PIN.
    ph1 = '{mk(0,0,0,0, 0,0,0,0,0,0), mk(1,1,4'hA,0, 0,0,0,0,0,0),
            mk(1,1,4'hC,0, 0,0,0,0,0,0), mk(1,1,4'h1,0, 0,0,0,1,0,0),
            mk(1,0,4'h0,0, 0,0,0,1,0,0), mk(1,1,4'h2,0, 0,0,0,2,0,0),
            mk(1,1,4'h3,0, 0,0,0,3,0,0), mk(1,1,4'h4,0, 1,0,0,0,0,0),
            mk(1,1,4'h5,0, 1,0,0,0,0,0)};
    // CLEAR mid-entry, three wrong PINs, correct PIN and hold edge during lockout.
    ph2 = '{mk(1,1,4'h7,0, 0,0,0,1,0,0), mk(1,1,4'hA,0, 0,0,0,0,0,0),
            mk(1,1,4'h9,0, 0,0,0,1,0,0), mk(1,1,4'h9,0, 0,0,0,2,0,0),
            mk(1,1,4'h9,0, 0,0,0,3,0,0), mk(1,1,4'h9,0, 0,0,0,0,1,0),
            mk(1,0,4'h0,0, 0,0,0,0,0,0),
            mk(1,1,4'h9,0, 0,0,0,1,0,0), mk(1,1,4'h9,0, 0,0,0,2,0,0),
            mk(1,1,4'h9,0, 0,0,0,3,0,0), mk(1,1,4'h9,0, 0,0,0,0,1,0),
            mk(1,0,4'h0,0, 0,0,0,0,0,0),
            mk(1,1,4'h9,0, 0,0,0,1,0,0), mk(1,1,4'h9,0, 0,0,0,2,0,0),
            mk(1,1,4'h9,0, 0,0,0,3,0,0), mk(1,1,4'h9,0, 0,1,0,0,1,0),
            mk(1,1,4'h1,0, 0,1,0,0,0,0), mk(1,1,4'h2,0, 0,1,0,0,0,0),
            mk(1,1,4'h3,0, 0,1,0,0,0,0), mk(1,1,4'h4,0, 0,1,0,0,0,0),
            mk(1,0,4'h0,1, 0,1,0,0,0,0), mk(1,0,4'h0,0, 0,1,0,0,0,0)};
    // One wrong PIN, then a partial entry left to time out.
    ph3a = '{mk(1,1,4'h9,0, 0,0,0,1,0,0), mk(1,1,4'h9,0, 0,0,0,2,0,0),
             mk(1,1,4'h9,0, 0,0,0,3,0,0), mk(1,1,4'h9,0, 0,0,0,0,1,0),
             mk(1,0,4'h0,0, 0,0,0,0,0,0),
             mk(1,1,4'h1,0, 0,0,0,1,0,0), mk(1,1,4'h2,0, 0,0,0,2,0,0)};
    // Two more wrong PINs: the second reaches MAX_TRIES only if the timeout kept tries.
    ph3b = '{mk(1,1,4'h9,0, 0,0,0,1,0,0), mk(1,1,4'h9,0, 0,0,0,2,0,0),
             mk(1,1,4'h9,0, 0,0,0,3,0,0), mk(1,1,4'h9,0, 0,0,0,0,1,0),
             mk(1,0,4'h0,0, 0,0,0,0,0,0),
             mk(1,1,4'h9,0, 0,0,0,1,0,0), mk(1,1,4'h9,0, 0,0,0,2,0,0),
             mk(1,1,4'h9,0, 0,0,0,3,0,0), mk(1,1,4'h9,0, 0,1,0,0,1,0),
             mk(0,0,4'h0,0, 0,0,0,0,0,0), mk(1,0,4'h0,0, 0,0,0,0,0,0)};
    // SETUP to 5678, old PIN rejected, new PIN opens, reset reverts, SETUP from UNLOCKED.
    ph4 = '{mk(1,0,4'h0,1, 0,0,1,0,0,0), mk(1,1,4'h5,1, 0,0,1,1,0,0),
            mk(1,1,4'h6,1, 0,0,1,2,0,0), mk(1,1,4'h7,1, 0,0,1,3,0,0),
            mk(1,1,4'h8,1, 0,0,0,0,0,1), mk(1,0,4'h0,0, 0,0,0,0,0,0),
            mk(1,1,4'h1,0, 0,0,0,1,0,0), mk(1,1,4'h2,0, 0,0,0,2,0,0),
            mk(1,1,4'h3,0, 0,0,0,3,0,0), mk(1,1,4'h4,0, 0,0,0,0,1,0),
            mk(1,0,4'h0,0, 0,0,0,0,0,0),
            mk(1,1,4'h5,0, 0,0,0,1,0,0), mk(1,1,4'h6,0, 0,0,0,2,0,0),
            mk(1,1,4'h7,0, 0,0,0,3,0,0), mk(1,1,4'h8,0, 1,0,0,0,0,0),
            mk(1,0,4'h0,0, 1,0,0,0,0,0), mk(0,0,4'h0,0, 0,0,0,0,0,0),
            mk(1,0,4'h0,0, 0,0,0,0,0,0),
            mk(1,1,4'h1,0, 0,0,0,1,0,0), mk(1,1,4'h2,0, 0,0,0,2,0,0),
            mk(1,1,4'h3,0, 0,0,0,3,0,0), mk(1,1,4'h4,0, 1,0,0,0,0,0),
            mk(1,0,4'h0,1, 0,0,1,0,0,0), mk(1,1,4'h1,1, 0,0,1,1,0,0),
            mk(1,1,4'hA,1, 0,0,1,0,0,0), mk(1,1,4'hF,1, 0,0,1,0,0,0)};
    // Key and hold edge in the same IDLE cycle: SETUP wins, key dropped.
    ph5 = '{mk(1,0,4'h0,0, 0,0,0,0,0,0), mk(1,1,4'h5,1, 0,0,1,0,0,0),
            mk(1,0,4'h0,1, 0,0,1,0,0,0), mk(1,1,4'h6,1, 0,0,1,1,0,0),
            mk(0,0,4'h0,0, 0,0,0,0,0,0)};

    reset      = 1'b0;
    key_valid  = 1'b0;
    key_code   = 4'h0;
    hold_reset = 1'b0;

    run(ph1, "basic");
    steps_until_low(8'h80, TOpen + 20, k, su);
    check_int("unlock_len", k, TOpen - 1);
    check(("after_unlock"), 0, outs(), 8'h00);

    run(ph2, "lockout");
    steps_until_low(8'h40, TLock + 20, k, su);
    check_int("lockout_len", k, TLock - 6);
    check_int("lockout_no_unlock", int'(su), 0);

    run(ph3a, "timeout");
    steps_until_low(8'h1C, TIdle + 20, k, su);
    check_int("entry_timeout", k, TIdle);
    check("after_timeout", 0, outs(), 8'h00);
    run(ph3b, "tries_kept");

    run(ph4, "setup");
    steps_until_low(8'h20, TIdle + 20, k, su);
    check_int("setup_timeout", k, TIdle - 1);
    check("after_setup_timeout", 0, outs(), 8'h00);

    run(ph5, "key_vs_hold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 SHALL have parameter PIN_DEFAULT, 16 bits, default 16'h1234, four BCD digits, most significant digit entered first.
REQ-002 SHALL have parameter TIME_OPEN, default 3000, unlock duration in clk cycles.
REQ-003 SHALL have parameter TIME_LOCKOUT, default 10000, lockout duration in clk cycles.
REQ-004 SHALL have parameter TIME_IDLE_OUT, default 5000, maximum clk cycles allowed between keys before entry aborts.
REQ-005 SHALL have parameter MAX_TRIES, default 3, consecutive wrong PINs that trigger lockout.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic on posedge.
REQ-007 SHALL have port reset, input, 1 bit, synchronous active-low reset.
REQ-008 SHALL have port key_valid, input, 1 bit, one-cycle strobe qualifying key_code.
REQ-009 SHALL have port key_code, input, 4 bits: 0-9 are digits, 4'hA is CLEAR, 4'hB-4'hF are ignored.
REQ-010 SHALL have port hold_reset, input, 1 bit, level from the 5 s hold detector, high while the button is held past threshold.
REQ-011 SHALL have port unlock, output, 1 bit, drives the lock actuator.
REQ-012 SHALL have port lockout, output, 1 bit, high during lockout.
REQ-013 SHALL have port setup_mode, output, 1 bit, high in SETUP.
REQ-014 SHALL have port digit_cnt, output, 3 bits, digits captured in the current entry (0-4).
REQ-015 SHALL have port err_pulse, output, 1 bit, one-cycle pulse on each wrong PIN.
REQ-016 SHALL have port pin_saved, output, 1 bit, one-cycle pulse when a new PIN is committed.

Function
REQ-017 SHALL implement states IDLE, ENTRY, UNLOCKED, LOCKOUT and SETUP; all outputs registered.
REQ-018 SHALL detect a hold_reset rising edge (registered previous value); a level that stays high SHALL NOT retrigger.
REQ-019 IDLE: a digit key SHALL be captured as digit 1, set digit_cnt=1 and move to ENTRY; CLEAR and codes B-F SHALL be ignored.
REQ-020 ENTRY: each digit key SHALL shift into a 16-bit entry register and increment digit_cnt; CLEAR SHALL return to IDLE without counting a try.
REQ-021 On the cycle the 4th digit is sampled, the block SHALL compare the 16-bit entry with the stored PIN; the result is visible on the next edge.
REQ-022 Match: SHALL enter UNLOCKED with unlock=1 and clear the try counter.
REQ-023 Mismatch: SHALL pulse err_pulse and increment the try counter; if the count reaches MAX_TRIES, SHALL enter LOCKOUT, otherwise IDLE; digit_cnt SHALL return to 0.
REQ-024 ENTRY and SETUP: the inactivity timer SHALL restart on every accepted key; at TIME_IDLE_OUT cycles without a key, SHALL return to IDLE with the try counter and PIN unchanged.
REQ-025 UNLOCKED: unlock SHALL stay high for exactly TIME_OPEN cycles, then the block SHALL return to IDLE; keys SHALL be ignored.
REQ-026 LOCKOUT: lockout SHALL stay high for exactly TIME_LOCKOUT cycles; keys and hold_reset edges SHALL be ignored; on exit SHALL clear the try counter and go to IDLE.
REQ-027 A hold_reset rising edge in IDLE or UNLOCKED SHALL enter SETUP (unlock drops), and SHALL be ignored in ENTRY and LOCKOUT.
REQ-028 SETUP: SHALL collect 4 digits; on the 4th, SHALL overwrite the stored PIN, pulse pin_saved, clear the try counter and go to IDLE; CLEAR SHALL restart the count at 0 and stay in SETUP.
REQ-029 If key_valid and a hold_reset rising edge occur in the same IDLE cycle, SETUP SHALL win and the key SHALL be discarded.
REQ-030 There SHALL be one shared 20-bit timer; it SHALL saturate and never wrap.

Reset
REQ-031 While reset=0 at a clock edge: state=IDLE, stored PIN=PIN_DEFAULT, tries=0, timer=0, all outputs=0.
REQ-032 Reset low in any state, including mid-entry or mid-unlock, SHALL abort the operation and restore the values in REQ-031 on that edge.

Verification
REQ-033 Keys 1,2,3,4 after reset -> unlock=1 from the edge after the 4th key for 3000 cycles, then 0; digit_cnt back to 0.
REQ-034 Three entries of 9,9,9,9 -> err_pulse three times, lockout=1 for 10000 cycles; a correct PIN during lockout -> no unlock.
REQ-035 hold_reset rises in IDLE, keys 5,6,7,8 -> pin_saved pulse; 1,2,3,4 -> err_pulse; 5,6,7,8 -> unlock.
REQ-036 Keys 1,2 then no key for 5000 cycles -> IDLE, digit_cnt=0, tries unchanged.
REQ-037 Reset low during UNLOCKED with a changed PIN -> unlock=0 next edge and PIN reverts to 1234.
REQ-038 key_valid and hold_reset rising in the same IDLE cycle -> setup_mode=1, digit_cnt=0.
